// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the word address to instruction memory and
// fills the IF/ID register, with stall hold and redirect-driven squashing of wrong-path fetches.
module fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'd0,
    parameter int          SQUASH_CYCLES = 1,
    parameter logic [31:0] NOP_WORD      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid,
    output logic [31:0] fetch_count
);

    typedef enum logic {RUN, SQUASH} state_t;

    // The redirect slot is itself the first discarded slot, so the counter covers the rest.
    localparam logic [2:0] SQUASH_RELOAD = 3'(SQUASH_CYCLES - 1);

    state_t      state;
    logic [2:0]  squash_cnt;
    logic [31:0] pc;

    assign imem_addr = pc;

    // NOTE: all state below is registered with non-blocking assignments so every branch
    // sees the pre-edge PC (ifid_pc <= pc must capture the old value, not the new target).
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            ifid_instr  <= NOP_WORD;
            ifid_pc     <= 32'd0;
            ifid_valid  <= 1'b0;
            fetch_count <= 32'd0;
            squash_cnt  <= 3'd0;
            state       <= RUN;
        end else if (redirect_valid) begin
            pc         <= redirect_target;
            ifid_instr <= NOP_WORD;
            ifid_pc    <= pc;
            ifid_valid <= 1'b0;
            if (SQUASH_CYCLES > 1) begin
                squash_cnt <= SQUASH_RELOAD;
                state      <= SQUASH;
            end else begin
                squash_cnt <= 3'd0;
                state      <= RUN;
            end
        end else if (!stall) begin
            pc      <= pc + 32'd1;
            ifid_pc <= pc;
            if (state == SQUASH) begin
                // Wrong-path word is dropped; the slot reaches decode as an invalid NOP.
                ifid_instr <= NOP_WORD;
                ifid_valid <= 1'b0;
                squash_cnt <= squash_cnt - 3'd1;
                if (squash_cnt == 3'd1) begin
                    state <= RUN;
                end
            end else begin
                ifid_instr  <= imem_instr;
                ifid_valid  <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (1 and 3 squash slots) share stimulus and are checked
// every cycle against a slot-level reference model, plus directed literal expectations.
module tb_fetch_unit;

    localparam logic [31:0] RPC_A = 32'd0;
    localparam int          SQ_A  = 1;
    localparam logic [31:0] RPC_B = 32'd5;
    localparam int          SQ_B  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;

    logic [31:0] imem_addr_a, imem_instr_a, ifid_instr_a, ifid_pc_a, fetch_count_a;
    logic [31:0] imem_addr_b, imem_instr_b, ifid_instr_b, ifid_pc_b, fetch_count_b;
    logic        ifid_valid_a, ifid_valid_b;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'd0:   return 32'h7000_0000;
            32'd1:   return 32'h4142_0C00;
            32'd2:   return 32'hF240_0001;
            default: return (addr * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    assign imem_instr_a = mem_word(imem_addr_a);
    assign imem_instr_b = mem_word(imem_addr_b);

    fetch_unit #(.RESET_PC(RPC_A), .SQUASH_CYCLES(SQ_A), .NOP_WORD(32'h0)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .imem_addr(imem_addr_a), .imem_instr(imem_instr_a),
        .ifid_instr(ifid_instr_a), .ifid_pc(ifid_pc_a), .ifid_valid(ifid_valid_a),
        .fetch_count(fetch_count_a)
    );

    fetch_unit #(.RESET_PC(RPC_B), .SQUASH_CYCLES(SQ_B), .NOP_WORD(32'h0)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .imem_addr(imem_addr_b), .imem_instr(imem_instr_b),
        .ifid_instr(ifid_instr_b), .ifid_pc(ifid_pc_b), .ifid_valid(ifid_valid_b),
        .fetch_count(fetch_count_b)
    );

    // Slot-level model: each non-stalled edge delivers the word at the current PC unless
    // slots remain to be discarded after a redirect.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] slot_pc;
        logic        valid;
        logic [31:0] delivered;
        int          discard;
    } model_t;

    model_t m[2];

    task automatic model_step(input int i, input logic [31:0] rpc, input int sq);
        if (rst) begin
            m[i].pc = rpc; m[i].instr = 32'h0; m[i].slot_pc = 32'h0;
            m[i].valid = 1'b0; m[i].delivered = 32'h0; m[i].discard = 0;
        end else if (redirect_valid) begin
            m[i].slot_pc = m[i].pc;
            m[i].pc      = redirect_target;
            m[i].instr   = 32'h0;
            m[i].valid   = 1'b0;
            m[i].discard = sq - 1;
        end else if (!stall) begin
            m[i].slot_pc = m[i].pc;
            if (m[i].discard > 0) begin
                m[i].instr   = 32'h0;
                m[i].valid   = 1'b0;
                m[i].discard = m[i].discard - 1;
            end else begin
                m[i].instr     = mem_word(m[i].pc);
                m[i].valid     = 1'b1;
                m[i].delivered = m[i].delivered + 32'd1;
            end
            m[i].pc = m[i].pc + 32'd1;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, RPC_A, SQ_A);
        model_step(1, RPC_B, SQ_B);
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic compare_dut(input string tag, input int i, input logic [31:0] addr,
                               input logic [31:0] instr, input logic [31:0] pc,
                               input logic valid, input logic [31:0] cnt);
        check({tag, ".imem_addr"},   addr,          m[i].pc);
        check({tag, ".ifid_instr"},  instr,         m[i].instr);
        check({tag, ".ifid_pc"},     pc,            m[i].slot_pc);
        check({tag, ".ifid_valid"},  32'(valid),    32'(m[i].valid));
        check({tag, ".fetch_count"}, cnt,           m[i].delivered);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            compare_dut("a", 0, imem_addr_a, ifid_instr_a, ifid_pc_a, ifid_valid_a, fetch_count_a);
            compare_dut("b", 1, imem_addr_b, ifid_instr_b, ifid_pc_b, ifid_valid_b, fetch_count_b);
        end
    end

    task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] tgt);
        rst = r; stall = s; redirect_valid = rv; redirect_target = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        #1;
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        chk_en = 1'b1;
        check("reset a.imem_addr", imem_addr_a, 32'd0);
        check("reset b.imem_addr", imem_addr_b, 32'd5);
        check("reset a.ifid_valid", 32'(ifid_valid_a), 32'd0);
        check("reset a.fetch_count", fetch_count_a, 32'd0);

        // In-order fetch of the first three words.
        run(1);
        check("run0 instr", ifid_instr_a, 32'h7000_0000);
        check("run0 pc", ifid_pc_a, 32'd0);
        check("run0 valid", 32'(ifid_valid_a), 32'd1);
        run(1);
        check("run1 instr", ifid_instr_a, 32'h4142_0C00);
        check("run1 pc", ifid_pc_a, 32'd1);
        run(1);
        check("run2 instr", ifid_instr_a, 32'hF240_0001);
        check("run2 pc", ifid_pc_a, 32'd2);
        check("run2 count", fetch_count_a, 32'd3);

        // Two-cycle stall at PC=4.
        run(1);
        check("pre-stall addr", imem_addr_a, 32'd4);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        check("stall addr", imem_addr_a, 32'd4);
        check("stall pc", ifid_pc_a, 32'd3);
        check("stall count", fetch_count_a, 32'd4);
        run(1);
        check("post-stall pc", ifid_pc_a, 32'd4);

        // Single-slot redirect from PC=13 to 7.
        run(8);
        check("pre-redirect addr", imem_addr_a, 32'd13);
        step(1'b0, 1'b0, 1'b1, 32'd7);
        check("redir valid", 32'(ifid_valid_a), 32'd0);
        check("redir instr", ifid_instr_a, 32'd0);
        check("redir addr", imem_addr_a, 32'd7);
        run(1);
        check("redir next pc", ifid_pc_a, 32'd7);
        check("redir next valid", 32'(ifid_valid_a), 32'd1);

        // Three-slot squash on b with a stall in the second slot.
        run(2);
        check("b pre-squash count", fetch_count_b, 32'd14);
        step(1'b0, 1'b0, 1'b1, 32'd20);
        run(1);
        check("b squash2 valid", 32'(ifid_valid_b), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        check("b squash stall count", fetch_count_b, 32'd14);
        run(1);
        check("b squash3 valid", 32'(ifid_valid_b), 32'd0);
        check("b squash3 count", fetch_count_b, 32'd14);
        run(1);
        check("b first valid pc", ifid_pc_b, 32'd22);
        check("b first valid flag", 32'(ifid_valid_b), 32'd1);
        check("b first valid count", fetch_count_b, 32'd15);

        // Redirect and stall together: redirect wins.
        step(1'b0, 1'b1, 1'b1, 32'd2);
        check("redir+stall a addr", imem_addr_a, 32'd2);
        check("redir+stall a valid", 32'(ifid_valid_a), 32'd0);
        check("redir+stall b addr", imem_addr_b, 32'd2);

        // Reset while b is squashing.
        step(1'b0, 1'b0, 1'b1, 32'd30);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("rst-squash b addr", imem_addr_b, 32'd5);
        check("rst-squash b valid", 32'(ifid_valid_b), 32'd0);
        check("rst-squash b count", fetch_count_b, 32'd0);
        run(1);
        check("rst-squash b run pc", ifid_pc_b, 32'd5);
        check("rst-squash b run valid", 32'(ifid_valid_b), 32'd1);

        // PC wrap.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        run(1);
        check("wrap a addr", imem_addr_a, 32'd0);
        check("wrap a pc", ifid_pc_a, 32'hFFFF_FFFF);
        check("wrap a valid", 32'(ifid_valid_a), 32'd1);

        // Randomized traffic, checked every cycle against the model.
        for (int k = 0; k < 3000; k++) begin
            logic r, s, rv;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 99) < 2);
            s   = ($urandom_range(0, 99) < 25);
            rv  = ($urandom_range(0, 99) < 12);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3)))
                                              : 32'($urandom_range(0, 63));
            step(r, s, rv, tgt);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
